// File: rtl/parity_frame_serializer_if.sv
// Word-in / bit-out bundle for parity_frame_serializer.
// The source drives the master side and the serializer drives the slave side.
interface parity_frame_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/parity_frame_serializer.sv
// Serializes DATA_W-bit words one bit per clock and appends a running-XOR parity bit.
// Define PARITY_ODD_EN for odd parity; the default build produces even parity.
module parity_frame_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  parity_frame_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef PARITY_ODD_EN
  localparam logic PARITY_INIT = 1'b1;
`else
  localparam logic PARITY_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic               accept;
  logic               last_bit;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign bus.in_ready = (state_q != DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  // The counter holds the index of the bit currently on ser_out.
  assign last_bit     = (cnt_q == CNT_W'(DATA_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default first on every comb output keeps unlisted paths from
    // inferring latches.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DATA;
      DATA:    if (last_bit) state_d = PARITY;
      PARITY:  state_d = accept ? DATA : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes next-cycle outputs so ser_* are registered; bit 0 of a word
  // therefore appears in the cycle right after its acceptance edge.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    if (accept) begin
      sreg_d      = shift_word(bus.in_data);
      cnt_d       = '0;
      acc_d       = PARITY_INIT ^ first_bit(bus.in_data);
      ser_out_d   = first_bit(bus.in_data);
      ser_valid_d = 1'b1;
    end else if (state_q == DATA) begin
      ser_valid_d = 1'b1;
      if (last_bit) begin
        ser_out_d  = acc_q;
        ser_last_d = 1'b1;
      end else begin
        ser_out_d = first_bit(sreg_q);
        acc_d     = acc_q ^ first_bit(sreg_q);
        sreg_d    = shift_word(sreg_q);
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Scoreboard bench for parity_frame_serializer (LSB-first main instance, MSB-first side instance).
// Expected parity follows PARITY_ODD_EN so the bench suits either build.
module tb_parity_frame_serializer;

  localparam int DATA_W = 8;

`ifdef PARITY_ODD_EN
  localparam logic P_INIT = 1'b1;
`else
  localparam logic P_INIT = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_serializer_if #(.DATA_W(DATA_W)) u_if ();
  parity_frame_serializer_if #(.DATA_W(DATA_W)) u_if2 ();

  parity_frame_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  parity_frame_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  exp_t sb_q[$];
  int   passed   = 0;
  int   failed   = 0;
  int   total    = 0;
  int   run_len  = 0;
  int   last_run = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return P_INIT ^ (^w);
  endfunction

  // Scoreboard consumer: every valid serial bit must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (u_if.ser_valid === 1'b1) begin
        run_len++;
        if (sb_q.size() == 0) begin
          check("unexpected_bit", u_if.ser_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ser_out", u_if.ser_out, e.b);
          check("ser_last", u_if.ser_last, e.last);
        end
        check("in_ready_in_frame", u_if.in_ready, u_if.ser_last);
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      check("busy_vs_valid", u_if.busy, u_if.ser_valid);
    end
  end

  // Offers a word, pushes its expected bits on acceptance (first `keep` entries only).
  task automatic send(input logic [DATA_W-1:0] w, input int keep = DATA_W + 1);
    bit accepted = 1'b0;
    @(negedge clk);
    u_if.in_data  = w;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (u_if.in_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      for (int i = 0; i < DATA_W && i < keep; i++) sb_q.push_back('{b: w[i], last: 1'b0});
      if (keep > DATA_W) sb_q.push_back('{b: parity_of(w), last: 1'b1});
      @(posedge clk);
      #1 u_if.in_valid = 1'b0;
    end else begin
      check("accept_timeout", u_if.in_ready, 1'b1);
      u_if.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && u_if.ser_valid === 1'b0) break;
    end
    #1;
    check("drain_queue_empty", sb_q.size(), 0);
    check("drain_idle", u_if.ser_valid, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] w2;
    logic [DATA_W:0]   exp2;

    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if2.in_valid = 1'b0;
    u_if2.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ser_valid", u_if.ser_valid, 1'b0);
    check("rst_ser_out", u_if.ser_out, 1'b0);
    check("rst_ser_last", u_if.ser_last, 1'b0);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_in_ready", u_if.in_ready, 1'b1);
    mon_en = 1'b1;

    // Single frames with distinct patterns.
    send(8'hA5); drain(); check("frame_len_A5", last_run, 9);
    send(8'h07); drain();
    send(8'h00); drain();
    send(8'hFF); drain(); check("frame_len_FF", last_run, 9);

    // Back-to-back: second word taken in the PARITY cycle, no gap.
    send(8'h01);
    send(8'h03);
    drain();
    check("b2b_run_len", last_run, 18);

    // Reset during data bit 4: only bits 0..4 are ever emitted.
    send(8'hFF, 5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ser_valid", u_if.ser_valid, 1'b0);
    check("abort_ser_last", u_if.ser_last, 1'b0);
    check("abort_busy", u_if.busy, 1'b0);
    check("abort_in_ready", u_if.in_ready, 1'b1);
    check("abort_run_len", last_run, 5);
    check("abort_queue_empty", sb_q.size(), 0);
    send(8'h01); drain(); check("post_abort_len", last_run, 9);

    // in_valid during DATA is ignored; in_data change after acceptance has no effect.
    send(8'h3C);
    repeat (2) @(negedge clk);
    u_if.in_data  = 8'hC3;
    u_if.in_valid = 1'b1;
    #1 check("no_ready_in_data", u_if.in_ready, 1'b0);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    drain();
    check("ignored_word_len", last_run, 9);
    repeat (5) @(negedge clk);
    check("no_extra_frame_valid", u_if.ser_valid, 1'b0);
    check("no_extra_frame_busy", u_if.busy, 1'b0);

    // Reset and in_valid together: reset wins.
    @(negedge clk);
    rst           = 1'b1;
    u_if.in_data  = 8'h55;
    u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    rst           = 1'b0;
    check("rst_wins_busy", u_if.busy, 1'b0);
    check("rst_wins_valid", u_if.ser_valid, 1'b0);
    @(negedge clk);
    check("rst_wins_still_idle", u_if.ser_valid, 1'b0);

    // MSB-first instance: 8'h80 -> 1 then seven 0s, then parity.
    w2   = 8'h80;
    exp2 = {w2, parity_of(w2)};
    @(negedge clk);
    u_if2.in_data  = w2;
    u_if2.in_valid = 1'b1;
    check("msb_in_ready", u_if2.in_ready, 1'b1);
    @(posedge clk);
    #1 u_if2.in_valid = 1'b0;
    for (int i = 0; i <= DATA_W; i++) begin
      @(negedge clk);
      check("msb_ser_valid", u_if2.ser_valid, 1'b1);
      check("msb_ser_out", u_if2.ser_out, exp2[DATA_W - i]);
      check("msb_ser_last", u_if2.ser_last, (i == DATA_W) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("msb_end_idle", u_if2.ser_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
